// File: rtl/control_pkg.sv
// Shared decode constants: opcodes, R-type funcs, ALU/extension encodings, control word type.
// Latency: none (definitions only).
// Backpressure: not applicable.
package control_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FUNC_NOP  = 6'b000000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;

  // ALU operation encodings; 2'b11 is reserved and never produced
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  // Immediate extension encodings; 2'b11 is reserved and never produced
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Full control word as carried from decode to the output register
  typedef struct packed {
    logic [1:0] aluop;
    logic       ifbeq;
    logic       memwrite;
    logic [1:0] extop;
    logic       regwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: op/func to the next control word.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output ctrl_t      ctrl_d_o
);

  // Decode table; anything unrecognised yields an all-zero word with only illegal set,
  // so no state-changing enable can fire for an unsupported encoding.
  always_comb begin
    ctrl_d_o = CTRL_ZERO;
    unique case (op_i)
      OP_RTYPE: begin
        // func only matters for R-type
        unique case (func_i)
          FUNC_ADDU: begin
            ctrl_d_o.regdst   = 1'b1;
            ctrl_d_o.regwrite = 1'b1;
            ctrl_d_o.aluop    = ALU_ADD;
          end
          FUNC_SUBU: begin
            ctrl_d_o.regdst   = 1'b1;
            ctrl_d_o.regwrite = 1'b1;
            ctrl_d_o.aluop    = ALU_SUB;
          end
          FUNC_NOP: begin
            ctrl_d_o = CTRL_ZERO;
          end
          default: begin
            ctrl_d_o.illegal = 1'b1;
          end
        endcase
      end
      OP_ORI: begin
        ctrl_d_o.regwrite = 1'b1;
        ctrl_d_o.alusrc   = 1'b1;
        ctrl_d_o.extop    = EXT_ZERO;
        ctrl_d_o.aluop    = ALU_OR;
      end
      OP_LW: begin
        ctrl_d_o.regwrite = 1'b1;
        ctrl_d_o.alusrc   = 1'b1;
        ctrl_d_o.memtoreg = 1'b1;
        ctrl_d_o.extop    = EXT_SIGN;
        ctrl_d_o.aluop    = ALU_ADD;
      end
      OP_SW: begin
        ctrl_d_o.memwrite = 1'b1;
        ctrl_d_o.alusrc   = 1'b1;
        ctrl_d_o.extop    = EXT_SIGN;
        ctrl_d_o.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_d_o.ifbeq = 1'b1;
        ctrl_d_o.extop = EXT_SIGN;
        ctrl_d_o.aluop = ALU_SUB;
      end
      OP_LUI: begin
        ctrl_d_o.regwrite = 1'b1;
        ctrl_d_o.alusrc   = 1'b1;
        ctrl_d_o.extop    = EXT_LUI;
        ctrl_d_o.aluop    = ALU_OR;
      end
      default: begin
        ctrl_d_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control.sv
// Main control unit: registered decode of op/func into datapath control signals.
// Latency: one clk cycle from op/func to outputs; reset clears outputs asynchronously.
// Backpressure: none; a new instruction is accepted every cycle.
module control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [1:0] aluop,
  output logic       ifbeq,
  output logic       memwrite,
  output logic [1:0] extop,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       alusrc,
  output logic       regdst,
  output logic       illegal
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .op_i     (op),
    .func_i   (func),
    .ctrl_d_o (ctrl_d)
  );

  // Output register; reset forces every output (including illegal) low immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_ZERO;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign aluop    = ctrl_q.aluop;
  assign ifbeq    = ctrl_q.ifbeq;
  assign memwrite = ctrl_q.memwrite;
  assign extop    = ctrl_q.extop;
  assign regwrite = ctrl_q.regwrite;
  assign memtoreg = ctrl_q.memtoreg;
  assign alusrc   = ctrl_q.alusrc;
  assign regdst   = ctrl_q.regdst;
  assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: directed cases, full op x func sweep, random stream.
// Latency: expects outputs one clk after inputs are applied.
// Backpressure: not applicable.
module tb_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] func;
  logic [1:0] aluop;
  logic       ifbeq;
  logic       memwrite;
  logic [1:0] extop;
  logic       regwrite;
  logic       memtoreg;
  logic       alusrc;
  logic       regdst;
  logic       illegal;

  int checks;
  int errors;

  control dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .func     (func),
    .aluop    (aluop),
    .ifbeq    (ifbeq),
    .memwrite (memwrite),
    .extop    (extop),
    .regwrite (regwrite),
    .memtoreg (memtoreg),
    .alusrc   (alusrc),
    .regdst   (regdst),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs as one vector: {regdst,alusrc,memtoreg,regwrite,extop,memwrite,ifbeq,aluop,illegal}
  function automatic logic [11:0] observed();
    return {regdst, alusrc, memtoreg, regwrite, extop, memwrite, ifbeq, aluop, illegal};
  endfunction

  // Reference: name the instruction first, then list its control values
  function automatic logic [11:0] model(input logic [5:0] o, input logic [5:0] f);
    string      name;
    logic       rd, as, mr, rw, mw, br, ill;
    logic [1:0] ext, alu;
    if (o == 6'h00) begin
      if (f == 6'h21)      name = "addu";
      else if (f == 6'h23) name = "subu";
      else if (f == 6'h00) name = "nop";
      else                 name = "bad";
    end else if (o == 6'h0d) name = "ori";
    else if (o == 6'h23)     name = "lw";
    else if (o == 6'h2b)     name = "sw";
    else if (o == 6'h04)     name = "beq";
    else if (o == 6'h0f)     name = "lui";
    else                     name = "bad";
    rd = 0; as = 0; mr = 0; rw = 0; mw = 0; br = 0; ill = 0; ext = 2'd0; alu = 2'd0;
    case (name)
      "addu": begin rd = 1; rw = 1; alu = 2'd0; end
      "subu": begin rd = 1; rw = 1; alu = 2'd1; end
      "ori":  begin rw = 1; as = 1; ext = 2'd0; alu = 2'd2; end
      "lw":   begin rw = 1; as = 1; mr = 1; ext = 2'd1; alu = 2'd0; end
      "sw":   begin mw = 1; as = 1; ext = 2'd1; alu = 2'd0; end
      "beq":  begin br = 1; ext = 2'd1; alu = 2'd1; end
      "lui":  begin rw = 1; as = 1; ext = 2'd2; alu = 2'd2; end
      "bad":  ill = 1;
      default: ;
    endcase
    return {rd, as, mr, rw, ext, mw, br, alu, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (op=%b func=%b t=%0t)", tag, got, exp, op, func, $time);
    end
  endtask

  // Mutual-exclusion rules on the state-changing enables
  task automatic check_invariants();
    check_eq("rw_mw_excl", {31'd0, regwrite & memwrite}, 32'd0);
    check_eq("beq_no_wr", {31'd0, ifbeq & (regwrite | memwrite)}, 32'd0);
  endtask

  // Apply one instruction, clock it, and compare a little after the edge
  task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f);
    op   = o;
    func = f;
    @(posedge clk);
    #1;
    check_eq(tag, {20'd0, observed()}, {20'd0, model(o, f)});
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    checks = 0;
    errors = 0;
    legal_ops[0] = 6'h00; legal_ops[1] = 6'h0d; legal_ops[2] = 6'h23;
    legal_ops[3] = 6'h2b; legal_ops[4] = 6'h04; legal_ops[5] = 6'h0f;

    // Reset held with beq on the inputs; outputs must stay zero across edges
    rst_n = 1'b0;
    op    = 6'b000100;
    func  = 6'b000000;
    #2;
    check_eq("reset_zero", {20'd0, observed()}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hold", {20'd0, observed()}, 32'd0);

    // Release between edges; first edge loads the beq decode
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("release_pre_edge", {20'd0, observed()}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("first_beq", {20'd0, observed()}, {20'd0, 12'b0000_01_01_01_0});
    check_eq("first_beq_model", {20'd0, observed()}, {20'd0, model(6'b000100, 6'b000000)});

    // Consecutive instruction stream
    step("addu", 6'b000000, 6'b100001);
    check_eq("addu_fixed", {20'd0, observed()}, {20'd0, 12'b1001_00_00_00_0});
    step("subu", 6'b000000, 6'b100011);
    step("ori",  6'b001101, 6'b000000);
    step("lw",   6'b100011, 6'b000000);
    check_eq("lw_fixed", {20'd0, observed()}, {20'd0, 12'b0111_01_00_00_0});
    step("sw",   6'b101011, 6'b000000);
    step("lui",  6'b001111, 6'b000000);
    check_eq("lui_fixed", {20'd0, observed()}, {20'd0, 12'b0101_10_00_10_0});
    step("nop",  6'b000000, 6'b000000);

    // Legal then illegal R-type func; illegal must clear on the next legal one
    step("rtype_addu", 6'b000000, 6'b100001);
    step("rtype_bad",  6'b000000, 6'b100010);
    check_eq("bad_fixed", {20'd0, observed()}, 32'd1);
    step("not_sticky", 6'b101011, 6'b111111);

    // func ignored for non-R-type
    step("ori_func", 6'b001101, 6'b100011);
    check_eq("ori_aluop", {30'd0, aluop}, 32'd2);
    check_eq("ori_extop", {30'd0, extop}, 32'd0);

    // Asynchronous reset mid-cycle while lw is registered
    step("lw_pre_rst", 6'b100011, 6'b000000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {20'd0, observed()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_discard", {20'd0, observed()}, 32'd0);

    // Exhaustive sweep
    for (int o = 0; o < 64; o++) begin
      for (int f = 0; f < 64; f++) begin
        step("sweep", 6'(o), 6'(f));
        check_invariants();
      end
    end

    // Random stream biased toward supported opcodes, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] ro, rf;
      rf = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) ro = legal_ops[$urandom_range(0, 5)];
      else                           ro = 6'($urandom_range(0, 63));
      if (ro == 6'h00 && $urandom_range(0, 2) == 0)
        rf = ($urandom_range(0, 1) == 0) ? 6'h21 : 6'h23;
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rand_rst", {20'd0, observed()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      step("random", ro, rf);
      check_invariants();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
